// File: rtl/hps_multi_addr_gen_if.sv
// hps_multi_addr_gen_if: start/backpressure handshake and read-port bundle for the HPS address sequencer
interface hps_multi_addr_gen_if #(
  parameter int K_WIDTH = 11,
  parameter int H_WIDTH = 3
);
  logic start;
  logic [H_WIDTH-1:0] num_harm;
  logic out_ready;
  logic [K_WIDTH-2:0] ram_addr;
  logic ram_enable;
  logic [K_WIDTH-2:0] k;
  logic [H_WIDTH-1:0] harm_idx;
  logic group_last;
  logic busy;
  logic done;
  modport master (
    output start, num_harm, out_ready,
    input ram_addr, ram_enable, k, harm_idx, group_last, busy, done
  );
  modport slave (
    input start, num_harm, out_ready,
    output ram_addr, ram_enable, k, harm_idx, group_last, busy, done
  );
endinterface

// File: rtl/hps_multi_addr_gen.sv
// hps_multi_addr_gen: sweeps fundamental bin k and issues magnitude reads at h*k for h = 1..n
module hps_multi_addr_gen #(
  parameter int K_WIDTH = 11,
  parameter int N_HARM_MAX = 5,
  parameter int H_WIDTH = 3
) (
  input logic clock,
  input logic reset,
  hps_multi_addr_gen_if.slave bus
);
  localparam int A_WIDTH = K_WIDTH - 1;
  localparam logic [K_WIDTH-1:0] ADDR_MAX = K_WIDTH'((1 << A_WIDTH) - 1);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;
  logic [H_WIDTH-1:0] n_q, h_q, n_in, n_last;
  logic [A_WIDTH-1:0] k_q, acc_sel;
  logic [K_WIDTH-1:0] acc [N_HARM_MAX];
  logic [K_WIDTH-1:0] acc_top;
  logic issue, wrap, last_group;
  // acc[i] tracks (i+1)*k by repeated addition, so no multiplier is needed
  assign n_in = (bus.num_harm == '0) ? H_WIDTH'(1)
              : (bus.num_harm > H_WIDTH'(N_HARM_MAX)) ? H_WIDTH'(N_HARM_MAX) : bus.num_harm;
  assign n_last = n_q - H_WIDTH'(1);
  assign wrap = h_q == n_last;
  assign issue = (state == RUN) && bus.out_ready;
  // next group would start past the top of the RAM; guard bit keeps this compare wrap-free
  assign last_group = (acc_top + K_WIDTH'(n_q)) > ADDR_MAX;
  // select the accumulator for the current harmonic and for the highest harmonic
  always_comb begin
    acc_sel = '0;
    acc_top = '0;
    for (int i = 0; i < N_HARM_MAX; i++) begin
      acc_sel = (h_q == H_WIDTH'(i)) ? acc[i][A_WIDTH-1:0] : acc_sel;
      acc_top = (n_last == H_WIDTH'(i)) ? acc[i] : acc_top;
    end
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // next state: FINISH follows the final read of the last group and lasts one cycle
  always_comb begin
    state_next = (state == IDLE) ? (bus.start ? RUN : IDLE)
               : (state == RUN) ? ((issue && wrap && last_group) ? FINISH : RUN)
               : IDLE;
  end
  // sweep counters: harm_idx steps every issue, k and accumulators step at group end
  always_ff @(posedge clock) begin
    if (reset) begin
      n_q <= '0;
      h_q <= '0;
      k_q <= '0;
      for (int i = 0; i < N_HARM_MAX; i++) acc[i] <= '0;
    end else if (state == IDLE && bus.start) begin
      n_q <= n_in;
      h_q <= '0;
      k_q <= '0;
      for (int i = 0; i < N_HARM_MAX; i++) acc[i] <= '0;
    end else if (issue) begin
      h_q <= wrap ? '0 : h_q + H_WIDTH'(1);
      if (wrap) begin
        k_q <= k_q + A_WIDTH'(1);
        for (int i = 0; i < N_HARM_MAX; i++) acc[i] <= acc[i] + K_WIDTH'(i + 1);
      end
    end
  end
  assign bus.ram_addr = acc_sel;
  assign bus.ram_enable = issue;
  assign bus.k = k_q;
  assign bus.harm_idx = h_q;
  assign bus.group_last = wrap;
  assign bus.busy = state == RUN;
  assign bus.done = state == FINISH;
endmodule

// File: tb/tb_hps_multi_addr_gen.sv
// tb_hps_multi_addr_gen: scoreboard bench for the HPS address sequencer at K_WIDTH=5, N_HARM_MAX=4
module tb_hps_multi_addr_gen;
  localparam int KW = 5;
  localparam int NH = 4;
  localparam int HW = 3;
  localparam int AMAX = (1 << (KW - 1)) - 1;
  typedef struct packed {
    logic [KW-2:0] addr;
    logic [KW-2:0] k;
    logic [HW-1:0] h;
    logic last;
  } rd_t;
  logic clock = 0;
  logic reset = 1;
  int checks = 0;
  int fails = 0;
  int reads = 0;
  int done_count = 0;
  rd_t exp_q[$];
  rd_t e;
  hps_multi_addr_gen_if #(.K_WIDTH(KW), .H_WIDTH(HW)) bus();
  hps_multi_addr_gen #(.K_WIDTH(KW), .N_HARM_MAX(NH), .H_WIDTH(HW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "watchdog");
  end
  // scoreboard: every issued read is compared against the oldest expected read
  always @(negedge clock) begin
    if (bus.done) done_count++;
    if (bus.ram_enable) begin
      reads++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read: got addr=%0d k=%0d h=%0d, none expected", bus.ram_addr, bus.k, bus.harm_idx);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ram_addr, bus.k, bus.harm_idx, bus.group_last} !== e) begin
          fails++;
          $display("FAIL read: got addr=%0d k=%0d h=%0d last=%0d, expected addr=%0d k=%0d h=%0d last=%0d",
                   bus.ram_addr, bus.k, bus.harm_idx, bus.group_last, e.addr, e.k, e.h, e.last);
        end
      end
    end
  end
  task automatic push_model(input int n);
    rd_t r;
    for (int kk = 0; n * kk <= AMAX; kk++)
      for (int h = 0; h < n; h++) begin
        r.addr = (KW-1)'((h + 1) * kk);
        r.k = (KW-1)'(kk);
        r.h = HW'(h);
        r.last = (h == n - 1);
        exp_q.push_back(r);
      end
  endtask
  task automatic start_sweep(input logic [HW-1:0] nh);
    reads = 0;
    done_count = 0;
    bus.num_harm = nh;
    bus.start = 1;
    @(posedge clock);
    #1;
    bus.start = 0;
  endtask
  task automatic wait_done(input int budget, output bit got, output bit prev_en,
                           output logic [KW-2:0] prev_addr, output logic busy_at_done);
    bit pe;
    logic [KW-2:0] pa;
    got = 0;
    pe = 0;
    pa = '0;
    prev_en = 0;
    prev_addr = '0;
    busy_at_done = 1'bx;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clock);
      if (bus.done) begin
        got = 1;
        prev_en = pe;
        prev_addr = pa;
        busy_at_done = bus.busy;
      end
      pe = bus.ram_enable;
      pa = bus.ram_addr;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    checks++;
    if ({bus.busy, bus.done, bus.ram_enable, bus.group_last} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: busy/done/en/last=%b, expected 0000", {bus.busy, bus.done, bus.ram_enable, bus.group_last});
    end
    checks++;
    if ({bus.ram_addr, bus.k, bus.harm_idx} !== '0) begin
      fails++;
      $display("FAIL reset_values: addr=%0d k=%0d h=%0d, expected 0", bus.ram_addr, bus.k, bus.harm_idx);
    end
  endtask
  task automatic test_sweep(input string name, input logic [HW-1:0] nh, input int n, input int n_reads, input bit check_latency);
    bit got, pe;
    logic [KW-2:0] pa;
    logic bd;
    push_model(n);
    start_sweep(nh);
    if (check_latency) begin
      @(negedge clock);
      checks++;
      if ({bus.busy, bus.ram_enable} !== 2'b11) begin
        fails++;
        $display("FAIL %s_first_read: busy/en=%b, expected 11", name, {bus.busy, bus.ram_enable});
      end
    end
    wait_done(200, got, pe, pa, bd);
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL %s_done_timeout: done=0, expected a done pulse", name);
    end
    checks++;
    if ({pe, pa} !== {1'b1, (KW-1)'(n * (AMAX / n))}) begin
      fails++;
      $display("FAIL %s_done_latency: prev en=%0d addr=%0d, expected en=1 addr=%0d", name, pe, pa, n * (AMAX / n));
    end
    checks++;
    if (bd !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_at_done: busy=%b, expected 0", name, bd);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (reads !== n_reads || exp_q.size() != 0 || done_count !== 1) begin
      fails++;
      $display("FAIL %s_totals: reads=%0d left=%0d dones=%0d, expected reads=%0d left=0 dones=1", name, reads, exp_q.size(), done_count, n_reads);
    end
  endtask
  task automatic test_stall;
    bit got, pe;
    logic [KW-2:0] pa;
    logic bd;
    push_model(3);
    start_sweep(3);
    repeat (7) begin
      @(posedge clock);
      #1;
    end
    bus.out_ready = 0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      checks++;
      if ({bus.ram_enable, bus.busy, bus.ram_addr, bus.k, bus.harm_idx, bus.group_last} !== {1'b0, 1'b1, 4'd4, 4'd2, 3'd1, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold%0d: en=%b busy=%b addr=%0d k=%0d h=%0d last=%b, expected en=0 busy=1 addr=4 k=2 h=1 last=0",
                 s, bus.ram_enable, bus.busy, bus.ram_addr, bus.k, bus.harm_idx, bus.group_last);
      end
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1;
    wait_done(200, got, pe, pa, bd);
    repeat (2) @(negedge clock);
    checks++;
    if (!got || reads !== 18 || exp_q.size() != 0 || done_count !== 1) begin
      fails++;
      $display("FAIL stall_totals: done=%0d reads=%0d left=%0d dones=%0d, expected 1/18/0/1", got, reads, exp_q.size(), done_count);
    end
  endtask
  task automatic test_start_ignored;
    bit got, pe;
    logic [KW-2:0] pa;
    logic bd;
    push_model(3);
    start_sweep(3);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    bus.start = 1;
    bus.num_harm = 1;
    @(posedge clock);
    #1;
    bus.start = 0;
    wait_done(200, got, pe, pa, bd);
    bus.start = 1;
    @(posedge clock);
    #1;
    bus.start = 0;
    repeat (4) @(negedge clock);
    checks++;
    if (!got || reads !== 18 || exp_q.size() != 0 || done_count !== 1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored: done=%0d reads=%0d left=%0d dones=%0d busy=%b, expected 1/18/0/1/0", got, reads, exp_q.size(), done_count, bus.busy);
    end
  endtask
  task automatic test_reset_abort;
    push_model(3);
    start_sweep(3);
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    checks++;
    if ({bus.busy, bus.ram_enable, bus.done, bus.group_last, bus.ram_addr, bus.k, bus.harm_idx} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: busy=%b en=%b done=%b last=%b addr=%0d k=%0d h=%0d, expected all 0",
               bus.busy, bus.ram_enable, bus.done, bus.group_last, bus.ram_addr, bus.k, bus.harm_idx);
    end
    exp_q.delete();
    repeat (4) @(negedge clock);
    checks++;
    if (done_count !== 0 || reads !== 7) begin
      fails++;
      $display("FAIL abort_no_done: dones=%0d reads=%0d, expected 0 dones and 7 reads", done_count, reads);
    end
    test_sweep("after_abort_n2", 3'd2, 2, 16, 1'b0);
  endtask
  initial begin
    bus.start = 0;
    bus.num_harm = '0;
    bus.out_ready = 1;
    test_reset();
    test_sweep("n3", 3'd3, 3, 18, 1'b1);
    test_sweep("n1", 3'd1, 1, 16, 1'b0);
    test_sweep("n0", 3'd0, 1, 16, 1'b0);
    test_sweep("n7_clamp", 3'd7, 4, 16, 1'b0);
    test_stall();
    test_start_ignored();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/hps_multi_addr_gen.md
Name: hps_multi_addr_gen

Overview:
- Read-address sequencer for the harmonic product spectrum stage.
- After the magnitude RAM holds a frame, it sweeps fundamental bin k and issues reads of |X[h*k]| for h = 1..num_harm.
- Each group of num_harm reads feeds the downstream multiply-accumulate, which forms the HPS product for bin k.
- Generalises the fixed 3-harmonic generator: runtime-selectable harmonic count, true h*k indexing without multipliers, start/busy/done handshake and downstream backpressure.

Parameters:
- K_WIDTH, 11: log2 of DFT length. Magnitude RAM depth is 2**(K_WIDTH-1). Address width is K_WIDTH-1.
- N_HARM_MAX, 5: maximum harmonic count supported; legal range 1..8.
- H_WIDTH, 3: width of num_harm and harm_idx; must satisfy 2**H_WIDTH > N_HARM_MAX.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle request to begin a sweep; honoured only in IDLE.
- num_harm, input, H_WIDTH: harmonic count, sampled when start is accepted.
- out_ready, input, 1: downstream can accept a read this cycle.
- ram_addr, output, K_WIDTH-1: magnitude RAM read address, equal to h*k.
- ram_enable, output, 1: read issued this cycle.
- k, output, K_WIDTH-1: fundamental bin of the current read.
- harm_idx, output, H_WIDTH: current h-1, counting 0..n-1.
- group_last, output, 1: current read is the last harmonic of bin k.
- busy, output, 1: sweep in progress.
- done, output, 1: one-cycle pulse at sweep completion.

Behaviour:
- Reset value of every output and register is 0; state = IDLE. Reset wins over every other input in the same cycle. Reset mid-sweep aborts immediately with no done pulse.
- Sampled count n:
  - num_harm = 0 is taken as n = 1.
  - num_harm > N_HARM_MAX is clamped to n = N_HARM_MAX.
  - n is held in a register for the whole sweep.
- States: IDLE, RUN, FINISH.
- IDLE -> RUN when start = 1. On entry, k = 0, harm_idx = 0, and every accumulator acc[h] = 0.
- RUN:
  - busy = 1.
  - ram_enable = out_ready (combinational AND with state == RUN).
  - ram_addr = acc[harm_idx]; k, harm_idx and group_last come from registers. All outputs hold while out_ready = 0.
- Issue cycle (ram_enable = 1):
  - If harm_idx < n-1: harm_idx increments.
  - Otherwise: harm_idx -> 0, k increments, and each acc[h] += h+1 for h = 0..N_HARM_MAX-1.
- No multipliers. Accumulators are K_WIDTH bits wide, one guard bit above the address width.
- group_last = (harm_idx == n-1).
- Termination:
  - The group issued at bin k is the last group when acc[n-1] + n > 2**(K_WIDTH-1) - 1, evaluated in K_WIDTH bits.
  - On the issue cycle of that group's final read, the next state is FINISH.
  - Every address issued is <= 2**(K_WIDTH-1) - 1; the sequencer never wraps.
- FINISH: lasts one cycle. done = 1, busy = 0, ram_enable = 0. Next state is IDLE.
- start while in RUN or FINISH is ignored; it is not queued.
- num_harm changes mid-sweep have no effect.
- Latency:
  - start accepted at cycle t: busy = 1 and the first read is possible at t+1.
  - Final read issued at cycle u: done = 1 at u+1.
- Read count per sweep: n * (floor((2**(K_WIDTH-1) - 1) / n) + 1).

Test Plan:
- K_WIDTH = 5, N_HARM_MAX = 4 for all cases. num_harm = 3, out_ready = 1 -> 18 reads:
  - addresses 0,0,0, 1,2,3, 2,4,6, 3,6,9, 4,8,12, 5,10,15;
  - k runs 0..5; group_last high on every third read;
  - done high exactly 1 cycle after address 15; busy low on that same cycle.
- num_harm = 1 -> 16 reads, addresses 0..15, group_last = 1 on every read, k equals ram_addr.
- num_harm = 0 -> identical to the num_harm = 1 case. num_harm = 7 -> clamped to n = 4, 16 reads, final group 3,6,9,12.
- num_harm = 3, out_ready forced low for 3 cycles while ram_addr = 4 (k = 2, harm_idx = 1):
  - ram_enable = 0 and all outputs held during the stall;
  - the sequence resumes with 4 then 6, and no address is skipped or duplicated.
- start pulsed again at the 5th read and during FINISH -> ignored: exactly one done pulse, and the sequence is unchanged.
- reset asserted at the 7th read -> next cycle busy = 0, ram_enable = 0, all outputs 0, no done pulse. A following start with num_harm = 2 gives a clean sweep of 16 reads: 0,0, 1,2, 2,4 ... 7,14.
